prince_ti_round_ctrl: RTL and testbench

Round sequencer for the 4-share threshold-implemented PRINCE encryption core. It steps the shared 64-bit state through the 12 S-box layers and the linear layers between them. It gates the single-stage TI S-box register on availability of fresh guard randomness for the changing-of-the-guards remasking, and it selects forward, middle and inverse layer modes and the round-constant index. The block sits between the top-level start/done interface and the shared datapath (state register, TI S-box layer, linear layer, key/RC addition).

---
 rtl/prince_ti_round_ctrl_if.sv | 28 ++
 rtl/prince_ti_round_ctrl.sv | 104 ++++++++++
 tb/tb_prince_ti_round_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/prince_ti_round_ctrl_if.sv
// Control bundle between the PRINCE TI round sequencer and its neighbours.
// master = sequencer side; slave = top-level / datapath / randomness side.
interface prince_ti_round_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       load_en;
    logic       sbox_en;
    logic       state_en;
    logic       inv_sel;
    logic [1:0] lin_mode;
    logic [3:0] rc_idx;
    logic       zeroize;

    modport master (
        input  start, rnd_valid,
        output busy, done, rnd_ready, load_en, sbox_en, state_en,
               inv_sel, lin_mode, rc_idx, zeroize
    );

    modport slave (
        output start, rnd_valid,
        input  busy, done, rnd_ready, load_en, sbox_en, state_en,
               inv_sel, lin_mode, rc_idx, zeroize
    );
endinterface

// File: rtl/prince_ti_round_ctrl.sv
// Round sequencer for the 4-share TI PRINCE core; option macro PRINCE_TI_ZEROIZE_EN adds a ZERO clear state.
// Latency: done 2*N_LAYERS+2 cycles after start is sampled, plus one cycle per randomness stall.
// Backpressure: each S-box layer waits in SBOX until rnd_valid; start is ignored while busy.
module prince_ti_round_ctrl #(
    parameter int N_LAYERS = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    prince_ti_round_ctrl_if.master  bus
);
    localparam int         MID    = N_LAYERS / 2 - 1;
    localparam logic [3:0] MID_K  = 4'(MID);
    localparam logic [3:0] LAST_K = 4'(N_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SBOX,
        S_LIN,
        S_DONE
`ifdef PRINCE_TI_ZEROIZE_EN
        , S_ZERO
`endif
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] k, k_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.rnd_ready = 1'b0;
        bus.load_en  = 1'b0;
        bus.sbox_en  = 1'b0;
        bus.state_en = 1'b0;
        bus.inv_sel  = 1'b0;
        bus.lin_mode = 2'd0;
        bus.rc_idx   = 4'd0;
        bus.zeroize  = 1'b0;

        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                bus.load_en = 1'b1;
                k_nxt       = 4'd0;
                state_nxt   = S_SBOX;
            end
            S_SBOX: begin
                // S-box register only advances on a completed randomness handshake
                bus.rnd_ready = 1'b1;
                bus.sbox_en   = bus.rnd_valid;
                bus.inv_sel   = (k > MID_K);
                if (bus.rnd_valid) state_nxt = S_LIN;
            end
            S_LIN: begin
                bus.state_en = 1'b1;
                bus.rc_idx   = k + 4'd1;
                bus.inv_sel  = (k > MID_K);
                if (k < MID_K)       bus.lin_mode = 2'd0;
                else if (k == MID_K) bus.lin_mode = 2'd1;
                else if (k < LAST_K) bus.lin_mode = 2'd2;
                else                 bus.lin_mode = 2'd3;
                if (k == LAST_K) begin
                    state_nxt = S_DONE;
                end else begin
                    k_nxt     = k + 4'd1;
                    state_nxt = S_SBOX;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
`ifdef PRINCE_TI_ZEROIZE_EN
                state_nxt = S_ZERO;
`else
                state_nxt = S_IDLE;
`endif
            end
`ifdef PRINCE_TI_ZEROIZE_EN
            S_ZERO: begin
                bus.zeroize = 1'b1;
                state_nxt   = S_IDLE;
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_prince_ti_round_ctrl.sv
// Bench for prince_ti_round_ctrl: table-driven stall runs, random stall/start runs, reset abort, held start.
module tb_prince_ti_round_ctrl;
    localparam int NL  = 12;
    localparam int MID = NL / 2 - 1;
`ifdef PRINCE_TI_ZEROIZE_EN
    localparam int ZX = 1;
`else
    localparam int ZX = 0;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rnd_ready;
        logic       load_en;
        logic       sbox_en;
        logic       state_en;
        logic       inv_sel;
        logic [1:0] lin_mode;
        logic [3:0] rc_idx;
        logic       zeroize;
    } out_t;

    typedef struct {
        int stall_layer;
        int stall_len;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    out_t exp_q[$];
    logic exp_rv[$];

    prince_ti_round_ctrl_if bus();
    prince_ti_round_ctrl #(.N_LAYERS(NL)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.busy = bus.busy;         o.done = bus.done;
        o.rnd_ready = bus.rnd_ready; o.load_en = bus.load_en;
        o.sbox_en = bus.sbox_en;   o.state_en = bus.state_en;
        o.inv_sel = bus.inv_sel;   o.lin_mode = bus.lin_mode;
        o.rc_idx = bus.rc_idx;     o.zeroize = bus.zeroize;
        return o;
    endfunction

    task automatic check_out(input string name, input int cyc, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Expected cycle-by-cycle trace of one run, derived from the schedule:
    // idle/start, load, then per layer (stalls, sbox, lin), done, optional zero, idle.
    task automatic build_trace(input int stalls[NL]);
        out_t o;
        exp_q.delete();
        exp_rv.delete();
        o = '0;
        exp_q.push_back(o); exp_rv.push_back(1'($urandom));
        o = '0; o.busy = 1; o.load_en = 1;
        exp_q.push_back(o); exp_rv.push_back(1'($urandom));
        for (int k = 0; k < NL; k++) begin
            for (int s = 0; s < stalls[k]; s++) begin
                o = '0; o.busy = 1; o.rnd_ready = 1; o.inv_sel = (k > MID);
                exp_q.push_back(o); exp_rv.push_back(1'b0);
            end
            o = '0; o.busy = 1; o.rnd_ready = 1; o.sbox_en = 1; o.inv_sel = (k > MID);
            exp_q.push_back(o); exp_rv.push_back(1'b1);
            o = '0; o.busy = 1; o.state_en = 1; o.inv_sel = (k > MID);
            o.rc_idx = 4'(k + 1);
            o.lin_mode = (k < MID) ? 2'd0 : (k == MID) ? 2'd1 : (k < NL - 1) ? 2'd2 : 2'd3;
            exp_q.push_back(o); exp_rv.push_back(1'($urandom));
        end
        o = '0; o.busy = 1; o.done = 1;
        exp_q.push_back(o); exp_rv.push_back(1'($urandom));
        if (ZX != 0) begin
            o = '0; o.busy = 1; o.zeroize = 1;
            exp_q.push_back(o); exp_rv.push_back(1'($urandom));
        end
        o = '0;
        exp_q.push_back(o); exp_rv.push_back(1'($urandom));
    endtask

    // Called just after a rising edge with the DUT idle. abort_at >= 0 asserts rst in that cycle.
    task automatic run_trace(input string name, input bit rand_start, input int abort_at,
                             output int got_done);
        int last;
        out_t act;
        got_done = -1;
        last = exp_q.size() - 1;
        if (abort_at >= 0) last = abort_at;
        for (int c = 0; c <= last; c++) begin
            bus.start     = (c == 0) ? 1'b1 : (rand_start && c != exp_q.size() - 1) ? 1'($urandom) : 1'b0;
            bus.rnd_valid = exp_rv[c];
            rst           = (c == abort_at);
            @(negedge clk);
            act = sample();
            if (act.done && got_done < 0) got_done = c;
            check_out(name, c, act, exp_q[c]);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        int   stalls[NL];
        int   got, sum, first_done, second_load, cyc;

        vecs[0] = '{-1, 0, 26};
        vecs[1] = '{4, 3, 29};
        vecs[2] = '{0, 1, 27};
        vecs[3] = '{11, 4, 30};
        vecs[4] = '{MID + 1, 2, 28};

        rst = 1'b1; bus.start = 1'b1; bus.rnd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_out("reset_outputs", 0, sample(), '0);
        @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            for (int k = 0; k < NL; k++) stalls[k] = (k == vecs[i].stall_layer) ? vecs[i].stall_len : 0;
            build_trace(stalls);
            run_trace("table_trace", 1'b0, -1, got);
            check_int("table_done_cycle", got, vecs[i].exp_done);
        end

        // reset during LIN of layer 7 (cycle 17), then a clean run
        for (int k = 0; k < NL; k++) stalls[k] = 0;
        build_trace(stalls);
        run_trace("abort_trace", 1'b0, 17, got);
        check_int("abort_no_done", got, -1);
        @(negedge clk);
        check_out("abort_idle", 18, sample(), '0);
        @(posedge clk); #1;
        build_trace(stalls);
        run_trace("after_abort", 1'b0, -1, got);
        check_int("after_abort_done", got, 26);

        for (int r = 0; r < 20; r++) begin
            sum = 0;
            for (int k = 0; k < NL; k++) begin
                stalls[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
                sum += stalls[k];
            end
            build_trace(stalls);
            run_trace("rand_trace", 1'b1, -1, got);
            check_int("rand_done_cycle", got, 2 * NL + 2 + sum);
        end

        // start held high: back-to-back runs
        first_done = -1; second_load = -1; cyc = 0;
        bus.start = 1'b1; bus.rnd_valid = 1'b1;
        while (second_load < 0 && cyc < 200) begin
            @(negedge clk);
            if (bus.done && first_done < 0) first_done = cyc;
            if (bus.load_en && first_done >= 0) second_load = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check_int("held_first_done", first_done, 26);
        check_int("held_reload_gap", second_load - first_done, 2 + ZX);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            if (!bus.busy) break;
            @(posedge clk); #1;
            cyc++;
        end
        check_int("held_drain_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
